// File: rtl/ram_pkg.sv
// +----------------------------------------------------------------------+
// | ram_pkg : shared types, constants and byte-merge helper for the RAM   |
// | responder.                                     Revision: 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

package ram_pkg;

  localparam int WORD_ADDR_LSB     = 2;
  localparam int DEFAULT_WB_DEPTH  = 4;
  localparam int DEFAULT_MEM_WORDS = 16384;

  // Wide enough for any word index a 32-bit byte address can carry.
  typedef logic [29:0] word_idx_t;

  typedef struct packed {
    word_idx_t   index;
    logic [31:0] data;
    logic [3:0]  be;
  } wb_entry_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_responder_if.sv
// +----------------------------------------------------------------------+
// | ram_responder_if : instruction-read / data-write bus between the core |
// | and the RAM responder.                         Revision: 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

interface ram_responder_if;

  logic        rd_ram_en;
  logic [15:0] rd_ram_addr;
  logic        rd_ram_stall;
  logic        rd_ram_valid;
  logic [31:0] rd_ram_data;
  logic        wr_ram_en;
  logic [31:0] wr_ram_addr;
  logic [31:0] wr_ram_data;
  logic [3:0]  wr_ram_be;
  logic        wr_ram_ready;

  modport master (
    output rd_ram_en, rd_ram_addr, wr_ram_en, wr_ram_addr, wr_ram_data, wr_ram_be,
    input  rd_ram_stall, rd_ram_valid, rd_ram_data, wr_ram_ready
  );

  modport slave (
    input  rd_ram_en, rd_ram_addr, wr_ram_en, wr_ram_addr, wr_ram_data, wr_ram_be,
    output rd_ram_stall, rd_ram_valid, rd_ram_data, wr_ram_ready
  );

endinterface

`default_nettype wire

// File: rtl/write_buffer_fifo.sv
// +----------------------------------------------------------------------+
// | write_buffer_fifo : circular posted-write FIFO with youngest-match    |
// | per-byte forwarding lookup.                    Revision: 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module write_buffer_fifo
  import ram_pkg::*;
#(
  parameter int DEPTH = DEFAULT_WB_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  input  word_idx_t        lookup_index,
  output logic [3:0]       fwd_hit,
  output logic [31:0]      fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("write_buffer_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  wb_entry_t        r_entries [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_slot;

  assign count = r_count;
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_entries[r_rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: only slots inside [rd_ptr, rd_ptr+count) are ever observed.
  always_ff @(posedge clk) begin
    if (push) r_entries[r_wr_ptr] <= push_entry;
  end

  // Walk oldest to youngest so a younger matching byte overrides an older one.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    w_slot   = r_rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      w_slot = r_rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < r_count && r_entries[w_slot].index == lookup_index) begin
        for (int b = 0; b < 4; b++) begin
          if (r_entries[w_slot].be[b]) begin
            fwd_hit[b]          = 1'b1;
            fwd_data[8*b +: 8]  = r_entries[w_slot].data[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_responder.sv
// +----------------------------------------------------------------------+
// | ram_responder : single-port word RAM serving core reads and posted    |
// | writes, reads prioritised over buffer drain.   Revision: 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module ram_responder
  import ram_pkg::*;
#(
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS,
  parameter int WB_DEPTH  = DEFAULT_WB_DEPTH
) (
  input  logic             clk,
  input  logic             reset_n,
  ram_responder_if.slave   bus
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(WB_DEPTH + 1);

  logic [31:0]      mem [MEM_WORDS];

  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_pop;
  logic [31:0]      w_rd_addr_ext;
  logic [IDX_W-1:0] w_rd_idx;
  wb_entry_t        w_wr_entry;
  wb_entry_t        w_head;
  logic [3:0]       w_fwd_hit;
  logic [31:0]      w_fwd_data;

  logic             r_rd_valid;
  logic [31:0]      r_mem_q;
  logic [3:0]       r_fwd_hit;
  logic [31:0]      r_fwd_data;
  logic             unused_bits;

  assign w_rd_addr_ext = {16'b0, bus.rd_ram_addr};
  assign w_rd_idx      = w_rd_addr_ext[IDX_W+1:WORD_ADDR_LSB];

  assign w_rd_acc = bus.rd_ram_en & ~w_full;
  assign w_wr_acc = bus.wr_ram_en & ~w_full;
  // Forced drain when full; otherwise drain only in cycles the read port leaves free.
  assign w_pop    = ~w_empty & (w_full | ~w_rd_acc);

  assign bus.wr_ram_ready = ~w_full;
  assign bus.rd_ram_stall = bus.rd_ram_en & w_full;
  assign bus.rd_ram_valid = r_rd_valid;
  assign bus.rd_ram_data  = merge_bytes(r_mem_q, r_fwd_data, r_fwd_hit);

  assign w_wr_entry.index = word_idx_t'(bus.wr_ram_addr[IDX_W+1:WORD_ADDR_LSB]);
  assign w_wr_entry.data  = bus.wr_ram_data;
  assign w_wr_entry.be    = bus.wr_ram_be;

  assign unused_bits = ^{w_rd_addr_ext[WORD_ADDR_LSB-1:0], w_rd_addr_ext[31:IDX_W+2],
                         bus.wr_ram_addr[WORD_ADDR_LSB-1:0], bus.wr_ram_addr[31:IDX_W+2],
                         w_head.index[29:IDX_W]};

  write_buffer_fifo #(
    .DEPTH (WB_DEPTH),
    .CNT_W (CNT_W)
  ) u_wb (
    .clk          (clk),
    .reset_n      (reset_n),
    .push         (w_wr_acc),
    .push_entry   (w_wr_entry),
    .pop          (w_pop),
    .head         (w_head),
    .count        (w_count),
    .full         (w_full),
    .empty        (w_empty),
    .lookup_index (word_idx_t'(w_rd_idx)),
    .fwd_hit      (w_fwd_hit),
    .fwd_data     (w_fwd_data)
  );

  // Resetting hit to all-ones makes the response word read as zero regardless of r_mem_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid <= 1'b0;
      r_fwd_hit  <= 4'hF;
      r_fwd_data <= '0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_fwd_hit  <= w_fwd_hit;
        r_fwd_data <= w_fwd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_rd_acc) r_mem_q <= mem[w_rd_idx];
    if (w_pop) begin
      for (int b = 0; b < 4; b++) begin
        if (w_head.be[b]) mem[w_head.index[IDX_W-1:0]][8*b +: 8] <= w_head.data[8*b +: 8];
      end
    end
  end

  a_no_x_data: assert property (@(posedge clk) disable iff (!reset_n)
    bus.rd_ram_valid |-> !$isunknown(bus.rd_ram_data));

  a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
    w_count <= CNT_W'(WB_DEPTH));

endmodule

`default_nettype wire

// File: tb/tb_ram_responder.sv
// +----------------------------------------------------------------------+
// | tb_ram_responder : directed and random checks of ram_responder        |
// | against a memory-level reference model.        Revision: 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ram_responder;

  localparam int WB_DEPTH  = 4;
  localparam int MEM_WORDS = 16384;

  typedef struct {
    int        idx;
    bit [31:0] d;
    bit [3:0]  be;
  } wr_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  ram_responder_if bus ();

  ram_responder #(
    .MEM_WORDS (MEM_WORDS),
    .WB_DEPTH  (WB_DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: 'logical' is what a read must return; 'committed' is what survives a reset.
  bit [31:0] logical   [MEM_WORDS];
  bit [31:0] committed [MEM_WORDS];
  wr_t       wq [$];
  bit [31:0] exp_data;

  function automatic bit [31:0] apply_be(bit [31:0] old_w, bit [31:0] new_w, bit [3:0] be);
    bit [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at posedge+1; drives one cycle of stimulus and checks it.
  task automatic do_cycle(input bit re, input logic [15:0] ra, input bit we,
                          input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] wbe);
    int  pre;
    bit  full, racc, wacc, pop;
    wr_t e;
    bus.rd_ram_en   = re;
    bus.rd_ram_addr = ra;
    bus.wr_ram_en   = we;
    bus.wr_ram_addr = wa;
    bus.wr_ram_data = wd;
    bus.wr_ram_be   = wbe;
    #1;
    pre  = wq.size();
    full = (pre == WB_DEPTH);
    racc = re && !full;
    wacc = we && !full;
    pop  = (pre > 0) && (full || !racc);
    check("wr_ready", {31'b0, bus.wr_ram_ready}, {31'b0, !full});
    check("rd_stall", {31'b0, bus.rd_ram_stall}, {31'b0, re && full});
    if (racc) exp_data = logical[int'(ra[15:2])];
    if (pop) begin
      e = wq.pop_front();
      committed[e.idx] = apply_be(committed[e.idx], e.d, e.be);
    end
    if (wacc) begin
      e.idx = int'(wa[15:2]);
      e.d   = wd;
      e.be  = wbe;
      logical[e.idx] = apply_be(logical[e.idx], wd, wbe);
      wq.push_back(e);
    end
    @(posedge clk);
    #1;
    check("rd_valid", {31'b0, bus.rd_ram_valid}, {31'b0, racc});
    check("rd_data", bus.rd_ram_data, exp_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 16'h0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic rd(input logic [15:0] a);
    do_cycle(1'b1, a, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    do_cycle(1'b0, 16'h0, 1'b1, a, d, be);
  endtask

  task automatic pulse_reset();
    bus.rd_ram_en = 1'b0;
    bus.wr_ram_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_ready", {31'b0, bus.wr_ram_ready}, 32'h1);
    check("rst_valid", {31'b0, bus.rd_ram_valid}, 32'h0);
    check("rst_data", bus.rd_ram_data, 32'h0);
    wq.delete();
    logical  = committed;
    exp_data = 32'h0;
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] addr_pool [20];

  initial begin
    checks   = 0;
    failures = 0;
    exp_data = 32'h0;
    reset_n  = 1'b0;
    bus.rd_ram_en   = 1'b0;
    bus.rd_ram_addr = '0;
    bus.wr_ram_en   = 1'b0;
    bus.wr_ram_addr = '0;
    bus.wr_ram_data = '0;
    bus.wr_ram_be   = '0;
    for (int i = 0; i < 16; i++) addr_pool[i] = 16'h0100 + 16'(4 * i);
    addr_pool[16] = 16'h0010;
    addr_pool[17] = 16'h0020;
    addr_pool[18] = 16'h0030;
    addr_pool[19] = 16'h0040;

    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_valid", {31'b0, bus.rd_ram_valid}, 32'h0);
    check("reset_data", bus.rd_ram_data, 32'h0);
    check("reset_ready", {31'b0, bus.wr_ram_ready}, 32'h1);
    check("reset_stall", {31'b0, bus.rd_ram_stall}, 32'h0);

    // Preload the array through the write port, then let it drain.
    wr(32'h10, 32'hDEADBEEF, 4'hF);
    wr(32'h20, 32'hAABBCCDD, 4'hF);
    wr(32'h30, 32'h00000005, 4'hF);
    wr(32'h40, 32'h01234567, 4'hF);
    for (int i = 0; i < 16; i++) wr({16'h0, addr_pool[i]}, $urandom, 4'hF);
    idle(WB_DEPTH + 1);

    rd(16'h0010);
    idle(1);

    wr(32'h10, 32'h11223344, 4'hF);
    rd(16'h0010);

    wr(32'h20, 32'h000000EE, 4'h1);
    wr(32'h20, 32'h0000FF00, 4'h2);
    rd(16'h0020);

    do_cycle(1'b1, 16'h0030, 1'b1, 32'h30, 32'h9, 4'hF);
    rd(16'h0030);

    // Fill under back-to-back reads, then hit the stall and forced drain.
    idle(WB_DEPTH + 1);
    for (int i = 0; i < WB_DEPTH; i++)
      do_cycle(1'b1, 16'h0040, 1'b1, 32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF);
    rd(16'h0100);
    rd(16'h0100);
    rd(16'h0104);

    // Reset with three writes buffered discards them.
    idle(WB_DEPTH + 1);
    for (int i = 0; i < 3; i++)
      do_cycle(1'b1, 16'h0040, 1'b1, 32'h110 + 32'(4 * i), 32'hBAD00000 + 32'(i), 4'hF);
    pulse_reset();
    for (int i = 0; i < 3; i++) rd(16'h0110 + 16'(4 * i));

    // Random traffic over the preloaded words, with aliasing upper address bits.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ra;
      logic [31:0] wa;
      ra = addr_pool[$urandom_range(0, 19)] | 16'($urandom_range(0, 3));
      wa = {16'($urandom), addr_pool[$urandom_range(0, 19)]} | 32'($urandom_range(0, 3));
      do_cycle(1'($urandom_range(0, 99) < 60), ra, 1'($urandom_range(0, 99) < 55), wa,
               $urandom, 4'($urandom_range(0, 15)));
    end
    idle(WB_DEPTH + 1);
    for (int i = 0; i < 20; i++) rd(addr_pool[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder serving the core's instruction-fetch read port and data write port.
- Models a single-port word RAM, so it holds a small posted-write buffer.
- Reads have priority over buffer draining; buffered writes are forwarded to reads byte-by-byte.
- Sits between exec_unit and the memory array, on the opposite end of the rd_ram_*/wr_ram_* interface.

Parameters:
- MEM_WORDS, 16384, number of 32-bit words in the array (64 KB, covers the 16-bit read address).
- WB_DEPTH, 4, posted-write buffer entries; must be a power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rd_ram_en  input  1  read request this cycle.
- rd_ram_addr  input  16  byte address; bits [1:0] ignored.
- rd_ram_stall  output  1  combinational; read in this cycle not accepted.
- rd_ram_valid  output  1  rd_ram_data holds the response to the read accepted last cycle.
- rd_ram_data  output  32  read response word.
- wr_ram_en  input  1  write request this cycle.
- wr_ram_addr  input  32  byte address; bits [1:0] ignored, bits above the array index ignored.
- wr_ram_data  input  32  write data.
- wr_ram_be  input  4  byte enables; bit i covers data[8i+7:8i].
- wr_ram_ready  output  1  combinational; buffer can accept a write this cycle.

Behaviour:
- Reset (async assert, sync release): rd_ram_valid=0, rd_ram_data=0, buffer empty, read/write pointers=0, count=0, wr_ram_ready=1, rd_ram_stall=0. Array contents are not reset. Reset mid-operation discards all buffered writes and any in-flight read response.
- Index: word index = addr[log2(MEM_WORDS)+1:2].
- full = (count==WB_DEPTH).
- wr_ram_ready = !full.
- Write accepted = wr_ram_en & wr_ram_ready. An accepted write is pushed at the write pointer as {index, data, be}. A write presented while full is ignored; the sender holds it until ready.
- rd_ram_stall = rd_ram_en & full. Read accepted = rd_ram_en & !full.
- Array port use per cycle, in priority order:
  - (1) full & count>0: forced drain.
  - (2) read accepted: array read.
  - (3) count>0 & no accepted read: drain.
  - (4) idle.
- Drain: oldest entry is written to the array under its be mask; pop; the read pointer advances.
- Read latency is exactly 1 cycle. Accepted at edge t, rd_ram_valid=1 and rd_ram_data valid after edge t+1. No accepted read at t gives rd_ram_valid=0 after t+1; rd_ram_data holds its previous value.
- Forwarding: response byte i is taken from the youngest buffer entry present before edge t whose index matches and be[i]=1, else from the array.
  - A write accepted in the same cycle as the read is not visible to that read (read-before-write).
  - A write accepted at cycle t is visible to reads at cycle t+1 onward, whether still buffered or drained.
- Count update: push only gives +1; pop only gives -1; push & pop gives unchanged. Pointers wrap modulo WB_DEPTH.
- Push cannot coincide with a forced drain, because full implies ready=0. Count never exceeds WB_DEPTH and never underflows.
- Continuous reads with count>0 and !full leave the buffer untouched. It drains only when full or when reads pause.
- Assertions: no X on rd_ram_data when rd_ram_valid=1; count<=WB_DEPTH.

Decomposition:
- Package ram_pkg:
  - typedef wb_entry_t {index, data[31:0], be[3:0]}.
  - constants WORD_ADDR_LSB=2 and the default for WB_DEPTH.
  - function merge_bytes(old, new, be).
- Sub-module write_buffer_fifo:
  - circular FIFO of wb_entry_t with push/pop/count/full/empty.
  - combinational youngest-match forwarding lookup, returning per-byte hit mask and data.
- ram_responder holds the array, the port-priority logic and the response register.

Test Plan:
- Reset, then read 0x0010 with the array preloaded 0xDEADBEEF → after one edge rd_ram_valid=1, rd_ram_data=0xDEADBEEF; no read next cycle → rd_ram_valid=0.
- Write 0x10 = 0x11223344 with be=1111, then read 0x10 the next cycle while the buffer is undrained → data 0x11223344 by forwarding.
- Array 0xAABBCCDD at 0x20:
  - write 0x20 data 0x000000EE be=0001;
  - then write 0x20 data 0x0000FF00 be=0010;
  - then read → 0xAABBFFEE.
- Same-cycle read and write to 0x30, old value 0x5 and new value 0x9 → response 0x5; a read the next cycle returns 0x9.
- Fill 4 writes under back-to-back reads → wr_ram_ready=0. The next read gives rd_ram_stall=1, rd_ram_valid=0 the cycle after, and the oldest entry drains. Then wr_ram_ready=1 and the read is accepted.
- Assert reset_n low with 3 writes buffered → count=0, wr_ram_ready=1 immediately. After release, reads of those addresses return the pre-write array values.
